// File: rtl/pwm.sv
// Free-running counter-based PWM generator: pwm_out is high while the
// period counter is below the live duty input.
module pwm #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] duty,
    output logic             pwm_out
);

    logic [WIDTH-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + WIDTH'(1);
        end
    end

    // Gated by reset so the output drops the instant reset asserts,
    // even though cnt=0 would otherwise compare high for nonzero duty.
    assign pwm_out = reset & (cnt < duty);

endmodule

// File: tb/tb_pwm.sv
// Self-checking bench for pwm: a 4-bit and an 8-bit instance share clock and
// reset; expected results are queued when stimulus is driven and popped on check.
module tb_pwm;

    logic       clk;
    logic       reset;
    logic [3:0] duty4;
    logic [7:0] duty8;
    logic       pwm4;
    logic       pwm8;

    int errors = 0;
    int checks = 0;
    int exp_q[$];

    pwm #(.WIDTH(4)) dut4 (
        .clk     (clk),
        .reset   (reset),
        .duty    (duty4),
        .pwm_out (pwm4)
    );

    pwm #(.WIDTH(8)) dut8 (
        .clk     (clk),
        .reset   (reset),
        .duty    (duty8),
        .pwm_out (pwm8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called right at a falling edge; samples n consecutive clocks 1ns later.
    task automatic measureWindow(input int n, output int highs4, output int highs8);
        highs4 = 0;
        highs8 = 0;
        for (int i = 0; i < n; i++) begin
            #1;
            highs4 += int'(pwm4);
            highs8 += int'(pwm8);
            @(negedge clk);
        end
    endtask

    task automatic checkOutput(input string tag, input int observed);
        int expected;
        expected = exp_q.pop_front();
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    initial begin
        int h4;
        int h8;

        reset = 1'b1;
        duty4 = 4'd9;
        duty8 = 8'd200;
        #2;
        reset = 1'b0;
        #1;
        exp_q.push_back(0);
        checkOutput("reset_pwm4", int'(pwm4));
        exp_q.push_back(0);
        checkOutput("reset_pwm8", int'(pwm8));
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Sweep even duty values, one full period each.
        for (int d = 0; d <= 14; d += 2) begin
            duty4 = 4'(d);
            exp_q.push_back(d);
            measureWindow(16, h4, h8);
            checkOutput($sformatf("sweep_duty%0d", d), h4);
        end

        duty4 = 4'd15;
        exp_q.push_back(15);
        measureWindow(16, h4, h8);
        checkOutput("duty15_window", h4);

        duty4 = 4'd0;
        exp_q.push_back(0);
        measureWindow(48, h4, h8);
        checkOutput("duty0_48clk", h4);

        // Mid-period reset with duty=8: bring counter to phase 3 first.
        duty4 = 4'd8;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        exp_q.push_back(1);
        checkOutput("pre_reset_high", int'(pwm4));
        reset = 1'b0;
        #1;
        exp_q.push_back(0);
        checkOutput("async_reset_drop", int'(pwm4));
        @(posedge clk);
        #1;
        exp_q.push_back(0);
        checkOutput("held_in_reset", int'(pwm4));
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back((i < 8) ? 1 : 0);
        end
        for (int i = 0; i < 16; i++) begin
            #1;
            checkOutput($sformatf("restart_clk%0d", i), int'(pwm4));
            @(negedge clk);
        end

        // Duty change at an arbitrary phase takes effect immediately.
        duty4 = 4'd5;
        repeat (7) @(negedge clk);
        duty4 = 4'd12;
        exp_q.push_back(12);
        measureWindow(16, h4, h8);
        checkOutput("duty5_to_12", h4);

        duty8 = 8'd128;
        exp_q.push_back(128);
        measureWindow(256, h4, h8);
        checkOutput("w8_duty128", h8);

        duty8 = 8'd255;
        exp_q.push_back(255);
        measureWindow(256, h4, h8);
        checkOutput("w8_duty255", h8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
